// File: rtl/ripple_counter_ctrl_pkg.sv
// Shared types and constants for the ripple counter run controller.
// Holds the FSM state encoding, the counter width and the wrap-detection helper.
package ripple_ctrl_pkg;

    localparam int                CNT_W   = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_t;

    // A wrap is the sampled count stepping from its top value back to zero.
    function automatic logic is_wrap(input logic [CNT_W-1:0] prev,
                                     input logic [CNT_W-1:0] cur);
        return (prev == CNT_MAX) && (cur == '0);
    endfunction

endpackage

// File: rtl/ripple_counter_ctrl_if.sv
// Control/status bundle between the run controller and the surrounding system.
// The slave modport is the controller's view; master is the system/counter side.
interface ripple_counter_ctrl_if;
    import ripple_ctrl_pkg::*;

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] passes;
    logic [CNT_W-1:0] q_in;
    logic             cnt_reset;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] pass_cnt;

    modport slave (
        input  start, abort, target, passes, q_in,
        output cnt_reset, busy, done, error, pass_cnt
    );

    modport master (
        output start, abort, target, passes, q_in,
        input  cnt_reset, busy, done, error, pass_cnt
    );

endinterface

// File: rtl/ripple_counter_ctrl_stall_watchdog.sv
// Counts consecutive enabled cycles where the sampled count did not move.
// o_stalled fires on the cycle the run length would reach STALL_MAX.
module stall_watchdog
    import ripple_ctrl_pkg::*;
#(
    parameter int STALL_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_q_s,
    input  logic [CNT_W-1:0] i_q_prev,
    output logic             o_stalled
);

    logic [7:0] r_cnt;
    logic       w_same;

    assign w_same = (i_q_s == i_q_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || !w_same) begin
            r_cnt <= '0;
        end else if (r_cnt != 8'(STALL_MAX)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_stalled = i_en && w_same && (r_cnt == 8'(STALL_MAX - 1));

endmodule

// File: rtl/ripple_counter_ctrl.sv
// Run controller for the 4-bit ripple counter: releases it on start, counts wraps,
// stops it at passes*16 + target and flags a stalled counter as a sticky error.
module ripple_counter_ctrl
    import ripple_ctrl_pkg::*;
#(
    parameter int STALL_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ripple_counter_ctrl_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_q_s;
    logic [CNT_W-1:0] r_q_prev;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_passes;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] w_pass_next;
    logic             w_wrap;
    logic             w_finish;
    logic             w_stalled;
    logic             w_accept;
    logic             r_cnt_reset;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    // The ripple output settles asynchronously, so every decision uses the registered copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_s    <= '0;
            r_q_prev <= '0;
        end else begin
            r_q_s    <= bus.q_in;
            r_q_prev <= r_q_s;
        end
    end

    assign w_wrap      = (r_state == ST_RUN) && is_wrap(r_q_prev, r_q_s);
    assign w_pass_next = (w_wrap && (r_pass_cnt != CNT_MAX)) ? r_pass_cnt + 1'b1 : r_pass_cnt;
    // Compare against the post-wrap pass count so a wrap to 0 can satisfy target 0.
    assign w_finish    = (w_pass_next == r_passes) && (r_q_s == r_target) && (r_q_s != r_q_prev);
    assign w_accept    = (r_state == ST_IDLE) && bus.start && !bus.abort;

    stall_watchdog #(
        .STALL_MAX (STALL_MAX)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (reset),
        .i_en      (r_state == ST_RUN),
        .i_q_s     (r_q_s),
        .i_q_prev  (r_q_prev),
        .o_stalled (w_stalled)
    );

    always_comb begin
        w_state_next = r_state;
        if (bus.abort) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) w_state_next = ST_CLEAR;
                end
                ST_CLEAR: begin
                    if ((r_target == '0) && (r_passes == '0)) w_state_next = ST_DONE;
                    else                                       w_state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (w_finish)       w_state_next = ST_DONE;
                    else if (w_stalled) w_state_next = ST_ERROR;
                end
                ST_DONE:  w_state_next = ST_IDLE;
                ST_ERROR: w_state_next = ST_ERROR;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_target   <= '0;
            r_passes   <= '0;
            r_pass_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_target   <= bus.target;
                r_passes   <= bus.passes;
                r_pass_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_pass_cnt <= w_pass_next;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_cnt_reset <= (w_state_next != ST_RUN);
            r_busy      <= (w_state_next == ST_CLEAR) || (w_state_next == ST_RUN);
            r_done      <= (w_state_next == ST_DONE);
            r_error     <= (w_state_next == ST_ERROR);
        end
    end

    assign bus.cnt_reset = r_cnt_reset;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.pass_cnt  = r_pass_cnt;

endmodule

// File: doc/ripple_counter_ctrl.md
# ripple_counter_ctrl

Run controller for the 4-bit `ripple_carry_counter` datapath. It holds the counter in reset until a `start` request arrives, then releases it. It tracks how many times the counter wraps and stops the counter after a programmed number of full passes plus a final target value. It also watches for a stalled counter and reports completion or error to the surrounding system.

## Interface
Parameters:
- `STALL_MAX`, 4: consecutive RUN cycles with an unchanged sampled count before the block declares a stall error (range 2–255).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. The block is in reset while `reset`=0.
- `start`  in  1  one-cycle run request; accepted only in IDLE.
- `abort`  in  1  level; returns any state to IDLE on the next edge.
- `target`  in  4  final count value; sampled when `start` is accepted.
- `passes`  in  4  number of full 0→15 wraps before `target` is honoured; sampled with `target`.
- `q_in`  in  4  counter output `q`.
- `cnt_reset`  out  1  drives the counter's active-high `reset`.
- `busy`  out  1  high in CLEAR and RUN.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  high while in ERROR.
- `pass_cnt`  out  4  wraps observed in the current or last run.

## Operation
- `q_in` is registered into `q_s` on every edge, because the ripple counter output settles asynchronously. All decisions use `q_s` and `q_prev` (the previous `q_s`).
- FSM states: IDLE, CLEAR, RUN, DONE, ERROR.
- IDLE: `cnt_reset`=1. On `start`, latch `target`/`passes`, clear `pass_cnt`, go to CLEAR.
- CLEAR: one cycle with `cnt_reset`=1.
  - If latched `target`=0 and `passes`=0, go to DONE.
  - Otherwise go to RUN.
- RUN: `cnt_reset`=0.
  - Wrap event is `q_prev`=15 and `q_s`=0. On a wrap, `pass_cnt` increments, saturating at 15.
  - Finish when `pass_cnt`=latched `passes` and `q_s`=latched `target` and `q_s`≠`q_prev`, then go to DONE.
  - A wrap to 0 counts as reaching `target`=0 only after `pass_cnt` has been updated.
- Stall watchdog: a counter clears whenever `q_s`≠`q_prev`, otherwise increments. When it reaches `STALL_MAX`, go to ERROR. The watchdog is active in RUN only.
- DONE: `cnt_reset`=1, `done`=1 for exactly one cycle, then IDLE.
- ERROR: `cnt_reset`=1, `error`=1. Sticky; exits only via `abort` to IDLE. `start` is ignored.
- `abort` has priority over all transitions, including a `start` or finish condition in the same cycle.
- `start` outside IDLE is ignored (no queuing).
- `pass_cnt` holds its value after DONE/ERROR until the next accepted `start`.

## Timing
- Reset values: state=IDLE, `cnt_reset`=1, `busy`=0, `done`=0, `error`=0, `pass_cnt`=0, `q_s`=0, `q_prev`=0, watchdog=0.
- `start` at edge k: CLEAR during cycle k+1. RUN begins at edge k+2, which is the first cycle with the counter released.
- Match latency: `q_in`=target in cycle m, `q_s` shows it in m+1, DONE in m+2.
  - The counter overruns `target` by up to 2 counts before `cnt_reset` takes effect. This is expected; `done` reports the logical match, not the frozen value.
- Run length for `passes`=P, `target`=T>0: about 16·P+T+3 cycles from `start` to `done`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `ripple_ctrl_pkg`: state enum (`ST_IDLE`, `ST_CLEAR`, `ST_RUN`, `ST_DONE`, `ST_ERROR`), `CNT_W`=4, `CNT_MAX`=15.
- Natural sub-module: `stall_watchdog`, which compares `q_s` against `q_prev` and runs a saturating counter against `STALL_MAX`, with an enable and a `stalled` output.
- Top level contains the input sampler, FSM, pass counter and output registers.

## Test plan
- Reset mid-RUN: drive `reset`=0 asynchronously in RUN. Expect immediate return to reset values: `cnt_reset`=1, `busy`=0, `pass_cnt`=0.
- `start` with `target`=5, `passes`=0, connected to a real counter: `busy` for 9 cycles, one `done` pulse, `pass_cnt`=0, `cnt_reset`=1 afterwards.
- `target`=3, `passes`=2: `pass_cnt` steps 1 then 2, `done` after about 38 cycles. A second `start` while busy is ignored.
- `target`=0, `passes`=0: CLEAR→DONE. `done` arrives 2 cycles after `start`, and `cnt_reset` never deasserts.
- Model `q_in` held at 7 during RUN with `STALL_MAX`=4: `error`=1 four cycles later and stays high. `start` is ignored; `abort` returns to IDLE with `error`=0.
- `abort` and the finish condition in the same cycle: no `done` pulse, state IDLE, `cnt_reset`=1.
